// File: rtl/mem_ctrl_pkg.sv
// Shared encodings, latencies and width defaults for the bram access path.
// Owner encodings are also used by the round-robin/lock arbiter.
package mem_ctrl_pkg;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_A    = 2'd1;
    localparam logic [1:0] OWNER_B    = 2'd2;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    localparam int READ_LATENCY = 1;
    // one cycle for the registered command plus the bram read latency
    localparam int ARB_LATENCY  = READ_LATENCY + 1;

    localparam int DEF_NUM_BLOCKS = 16;
    localparam int DEF_ADDR_BITS  = 8;
    localparam int DEF_DATA_BITS  = 16;

    typedef struct packed {
        logic valid;
        logic port_b;
    } rd_tag_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter with a bounded ownership lock.
// Grants are combinational from registered state; nothing is granted until one clock after reset.
module arb_rr2
    import mem_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic a_req,
    input  logic a_lock,
    input  logic b_req,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic          active;
    logic          rr_ptr;
    logic [1:0]    owner;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_inc;
    logic          a_keep;
    logic          b_keep;

    always_comb begin
        a_keep   = (owner == OWNER_A) && a_lock && (hold_cnt < HOLD_MAX);
        b_keep   = (owner == OWNER_B) && b_lock && (hold_cnt < HOLD_MAX);
        hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        a_gnt    = active && a_req && (!b_req || a_keep || (!b_keep && rr_ptr == RR_A));
        b_gnt    = active && b_req && !a_gnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active   <= 1'b0;
            rr_ptr   <= RR_A;
            owner    <= OWNER_NONE;
            hold_cnt <= '0;
        end else begin
            active <= 1'b1;
            if (a_gnt) begin
                rr_ptr   <= RR_B;
                owner    <= OWNER_A;
                hold_cnt <= (owner == OWNER_A && a_lock) ? hold_inc : '0;
            end else if (b_gnt) begin
                rr_ptr   <= RR_A;
                owner    <= OWNER_B;
                hold_cnt <= (owner == OWNER_B && b_lock) ? hold_inc : '0;
            end else begin
                owner    <= OWNER_NONE;
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares one bram port between the UART command port (A) and the background engine (B).
// Registered memory command, read-tag pipe and per-port read data return.
module bram_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int SEL_BITS   = $clog2(NUM_BLOCKS),
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int MAX_HOLD   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          a_req,
    input  logic                          a_we,
    input  logic                          a_lock,
    input  logic [SEL_BITS+ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0]          a_wdata,
    output logic                          a_gnt,
    output logic                          a_rvalid,
    output logic [DATA_BITS-1:0]          a_rdata,
    input  logic                          b_req,
    input  logic                          b_we,
    input  logic                          b_lock,
    input  logic [SEL_BITS+ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0]          b_wdata,
    output logic                          b_gnt,
    output logic                          b_rvalid,
    output logic [DATA_BITS-1:0]          b_rdata,
    output logic                          rd_en,
    output logic                          wr_en,
    output logic [SEL_BITS+ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0]          mem_wdata,
    input  logic [DATA_BITS-1:0]          mem_rdata
);

    localparam int AW = SEL_BITS + ADDR_BITS;

    logic                 gnt_any;
    logic                 cmd_we;
    logic [AW-1:0]        cmd_addr;
    logic [DATA_BITS-1:0] cmd_wdata;
    rd_tag_t              tag_pipe [ARB_LATENCY];
    logic [DATA_BITS-1:0] a_rdata_q;
    logic [DATA_BITS-1:0] b_rdata_q;

    arb_rr2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .a_req  (a_req),
        .a_lock (a_lock),
        .b_req  (b_req),
        .b_lock (b_lock),
        .a_gnt  (a_gnt),
        .b_gnt  (b_gnt)
    );

    always_comb begin
        gnt_any   = a_gnt | b_gnt;
        cmd_we    = a_we;
        cmd_addr  = a_addr;
        cmd_wdata = a_wdata;
        if (b_gnt) begin
            cmd_we    = b_we;
            cmd_addr  = b_addr;
            cmd_wdata = b_wdata;
        end
    end

    // address/data only move on a grant so the bram sees stable values while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_en     <= 1'b0;
            wr_en     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rd_en <= gnt_any & ~cmd_we;
            wr_en <= gnt_any & cmd_we;
            if (gnt_any) begin
                mem_addr  <= cmd_addr;
                mem_wdata <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ARB_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: gnt_any & ~cmd_we, port_b: b_gnt};
            for (int i = 1; i < ARB_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign a_rvalid = tag_pipe[ARB_LATENCY-1].valid & ~tag_pipe[ARB_LATENCY-1].port_b;
    assign b_rvalid = tag_pipe[ARB_LATENCY-1].valid &  tag_pipe[ARB_LATENCY-1].port_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_rvalid) a_rdata_q <= mem_rdata;
            if (b_rvalid) b_rdata_q <= mem_rdata;
        end
    end

    // present bram data in the rvalid cycle itself, then hold it until the port's next read
    assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
    assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: bram model, reference memory and scoreboard queues
// for memory commands and per-port read returns, plus directed scenario tasks.
module tb_bram_access_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          a_req = 0, a_we = 0, a_lock = 0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 0, b_we = 0, b_lock = 0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          rd_en, wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rd_t;

    cmd_t          cmd_q[$];
    rd_t           a_q[$];
    rd_t           b_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] bram [0:(1<<AW)-1];

    bram_access_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_lock    (a_lock),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_lock    (b_lock),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial for (int i = 0; i < (1 << AW); i++) bram[i] = '0;

    always @(posedge clk) begin
        if (wr_en) bram[mem_addr] <= mem_wdata;
        if (rd_en) mem_rdata <= bram[mem_addr];
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : '0;
    endfunction

    // Scoreboard: compare what is due this cycle, then record this cycle's grants.
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            if ((a_gnt && b_gnt) || (a_gnt && !a_req) || (b_gnt && !b_req)) begin
                errors++;
                $display("FAIL grant_excl cyc=%0d a_gnt=%b b_gnt=%b a_req=%b b_req=%b",
                         cyc, a_gnt, b_gnt, a_req, b_req);
            end
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                cmd_t c;
                c = cmd_q.pop_front();
                checks++;
                if ({wr_en, rd_en, mem_addr, mem_wdata} !== {c.we, ~c.we, c.addr, c.wdata}) begin
                    errors++;
                    $display("FAIL mem_cmd cyc=%0d got wr=%b rd=%b addr=%h wdata=%h exp wr=%b rd=%b addr=%h wdata=%h",
                             cyc, wr_en, rd_en, mem_addr, mem_wdata, c.we, ~c.we, c.addr, c.wdata);
                end
            end else if (rd_en || wr_en) begin
                checks++;
                errors++;
                $display("FAIL mem_cmd_unexpected cyc=%0d rd_en=%b wr_en=%b exp 0", cyc, rd_en, wr_en);
            end
            if (a_q.size() > 0 && a_q[0].cyc == cyc) begin
                rd_t r;
                r = a_q.pop_front();
                checks++;
                if (a_rvalid !== 1'b1 || a_rdata !== r.data) begin
                    errors++;
                    $display("FAIL a_read cyc=%0d got rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                             cyc, a_rvalid, a_rdata, r.data);
                end
            end else if (a_rvalid) begin
                checks++;
                errors++;
                $display("FAIL a_rvalid_unexpected cyc=%0d got 1 exp 0", cyc);
            end
            if (b_q.size() > 0 && b_q[0].cyc == cyc) begin
                rd_t r;
                r = b_q.pop_front();
                checks++;
                if (b_rvalid !== 1'b1 || b_rdata !== r.data) begin
                    errors++;
                    $display("FAIL b_read cyc=%0d got rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                             cyc, b_rvalid, b_rdata, r.data);
                end
            end else if (b_rvalid) begin
                checks++;
                errors++;
                $display("FAIL b_rvalid_unexpected cyc=%0d got 1 exp 0", cyc);
            end
            if (a_gnt) begin
                cmd_q.push_back('{cyc + 1, a_we, a_addr, a_wdata});
                if (a_we) ref_mem[a_addr] = a_wdata;
                else a_q.push_back('{cyc + 2, ref_read(a_addr)});
            end
            if (b_gnt) begin
                cmd_q.push_back('{cyc + 1, b_we, b_addr, b_wdata});
                if (b_we) ref_mem[b_addr] = b_wdata;
                else b_q.push_back('{cyc + 2, ref_read(b_addr)});
            end
        end
    end

    task automatic access(input bit pb, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        bit granted = 0;
        if (pb) begin
            b_req = 1; b_we = we; b_addr = addr; b_wdata = data;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_wdata = data;
        end
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            granted = pb ? b_gnt : a_gnt;
        end
        checks++;
        if (!granted) begin
            errors++;
            $display("FAIL access_timeout port_b=%b got no gnt exp gnt within 20 cycles", pb);
        end
        @(posedge clk);
        #1;
        if (pb) b_req = 0;
        else a_req = 0;
    endtask

    task automatic test_reset();
        resetn = 0; a_req = 1; b_req = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, rd_en, wr_en, a_rvalid, b_rvalid} !== 6'b0 ||
            a_rdata !== '0 || b_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b%b rd=%b wr=%b rv=%b%b addr=%h exp all 0",
                     a_gnt, b_gnt, rd_en, wr_en, a_rvalid, b_rvalid, mem_addr);
        end
        @(posedge clk);
        #1;
        a_req = 0; b_req = 0; resetn = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_port();
        access(0, 1, 12'h310, 16'h1234);
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || rd_en !== 1'b0 || mem_addr !== 12'h310 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL single_write got wr=%b rd=%b addr=%h data=%h exp wr=1 rd=0 addr=310 data=1234",
                     wr_en, rd_en, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_write_len got wr_en=%b exp 0", wr_en);
        end
        @(posedge clk);
        #1;
        access(0, 0, 12'h310, 16'h0);
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL single_rd_en got %b exp 1", rd_en);
        end
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL single_read got rvalid=%b rdata=%h exp rvalid=1 rdata=1234", a_rvalid, a_rdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL single_hold got rvalid=%b rdata=%h exp rvalid=0 rdata=1234", a_rvalid, a_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    // After a B access rr_ptr points to A, so contention alternates A,B,A,...
    task automatic test_contention();
        access(1, 1, 12'h520, 16'h5555);
        @(posedge clk);
        #1;
        a_we = 0; a_addr = 12'h310; b_we = 0; b_addr = 12'h520;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_order i=%0d got a_gnt=%b b_gnt=%b exp a_gnt=%b b_gnt=%b",
                         i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
            end
        end
        @(posedge clk);
        #1;
        a_req = 0; b_req = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (a_rdata !== 16'h1234 || b_rdata !== 16'h5555) begin
            errors++;
            $display("FAIL rr_routing got a_rdata=%h b_rdata=%h exp 1234 5555", a_rdata, b_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        int a_cnt = 0;
        int b_at = -1;
        a_we = 0; a_addr = 12'h310; b_we = 0; b_addr = 12'h520;
        a_lock = 1; a_req = 1; b_req = 1;
        for (int i = 0; i < 12 && b_at < 0; i++) begin
            @(negedge clk);
            if (a_gnt) a_cnt++;
            if (b_gnt) b_at = i;
        end
        checks++;
        if (a_cnt !== 5 || b_at !== 5) begin
            errors++;
            $display("FAIL lock_hold got a_grants=%0d b_wait=%0d exp a_grants=5 b_wait=5", a_cnt, b_at);
        end
        @(posedge clk);
        #1;
        a_lock = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL unlock_rr i=%0d got a_gnt=%b b_gnt=%b exp a_gnt=%b b_gnt=%b",
                         i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
            end
        end
        @(posedge clk);
        #1;
        a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_hazard();
        fork
            access(0, 1, 12'h700, 16'hBEEF);
            access(1, 0, 12'h700, 16'h0);
        join
        repeat (4) @(negedge clk);
        checks++;
        if (b_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL raw_hazard got b_rdata=%h exp beef", b_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_read();
        access(0, 0, 12'h310, 16'h0);
        resetn = 0;
        cmd_q.delete();
        a_q.delete();
        b_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_late i=%0d got a_rvalid=%b b_rvalid=%b rd_en=%b exp 0",
                         i, a_rvalid, b_rvalid, rd_en);
            end
        end
        @(posedge clk);
        #1;
        access(0, 0, 12'h310, 16'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL reset_mid_next got rvalid=%b rdata=%h exp rvalid=1 rdata=1234", a_rvalid, a_rdata);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_port();
        test_contention();
        test_lock();
        test_hazard();
        test_reset_mid_read();
        checks++;
        if (cmd_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got cmd=%0d a=%0d b=%0d pending exp 0",
                     cmd_q.size(), a_q.size(), b_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
